// File: rtl/synapse_table.sv
`default_nettype none
// ============================================================================
// Module   : synapse_table
// Purpose  : Per-neuron synapse weight store with overwrite/saturating-delta
//            STDP writes and a one-entry-per-cycle clear sweep.
//            Optional build macro SYNAPSE_WEIGHT_DECAY_EN adds a decay sweep.
// Revision : 1.0 - initial release
// ============================================================================
module synapse_table #(
  parameter int NEURON_W    = 7,
  parameter int WEIGHT_W    = 8,
  parameter int DELTA_W     = 4,
  parameter int INIT_WEIGHT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                kill,
  input  logic [NEURON_W-1:0] neuron_number,
  input  logic                R_EN,
  input  logic                W_EN,
  input  logic                w_mode,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic [DELTA_W-1:0]  delta,
`ifdef SYNAPSE_WEIGHT_DECAY_EN
  input  logic                decay_req,
`endif
  output logic [WEIGHT_W-1:0] out_weight,
  output logic                out_valid,
  output logic                busy
);

  localparam int DEPTH = 2**NEURON_W;
  localparam int SUM_W = WEIGHT_W + 2;

  localparam logic [1:0] S_SWEEP = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
`ifdef SYNAPSE_WEIGHT_DECAY_EN
  localparam logic [1:0] S_DECAY = 2'd2;
`endif

  localparam logic [NEURON_W-1:0] C_LAST = NEURON_W'(DEPTH - 1);
  localparam logic [WEIGHT_W-1:0] C_INIT = WEIGHT_W'(INIT_WEIGHT);
  localparam logic [WEIGHT_W-1:0] C_MAX  = {WEIGHT_W{1'b1}};

  logic [1:0]          r_state, w_state_nxt;
  logic [NEURON_W-1:0] r_idx, w_idx_nxt;
  logic                r_busy;
  logic [WEIGHT_W-1:0] r_mem [DEPTH];

  logic                w_we;
  logic                w_rd_acc;
  logic [NEURON_W-1:0] w_addr;
  logic [WEIGHT_W-1:0] w_wdata;
  logic [WEIGHT_W-1:0] w_cur;
  logic [WEIGHT_W-1:0] w_sat;
  logic signed [SUM_W-1:0] w_cur_ext, w_delta_ext, w_sum;

  assign w_cur       = r_mem[w_addr];
  assign w_cur_ext   = {2'b00, w_cur};
  assign w_delta_ext = {{(SUM_W-DELTA_W){delta[DELTA_W-1]}}, delta};
  assign w_sum       = w_cur_ext + w_delta_ext;

  // Negative sums clamp to 0, sums past the weight range clamp to all-ones.
  always_comb begin
    w_sat = w_sum[WEIGHT_W-1:0];
    if (w_sum[SUM_W-1])
      w_sat = '0;
    else if (w_sum[WEIGHT_W])
      w_sat = C_MAX;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_SWEEP;
      r_idx   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (kill) begin
      w_state_nxt = S_SWEEP;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        S_SWEEP: begin
          w_idx_nxt = r_idx + 1'b1;
          if (r_idx == C_LAST)
            w_state_nxt = S_IDLE;
        end
`ifdef SYNAPSE_WEIGHT_DECAY_EN
        S_DECAY: begin
          w_idx_nxt = r_idx + 1'b1;
          if (r_idx == C_LAST)
            w_state_nxt = S_IDLE;
        end
        S_IDLE: begin
          if (decay_req) begin
            w_state_nxt = S_DECAY;
            w_idx_nxt   = '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    w_we     = 1'b0;
    w_rd_acc = 1'b0;
    w_addr   = neuron_number;
    w_wdata  = weight;
    if (!kill) begin
      case (r_state)
        S_SWEEP: begin
          w_we    = 1'b1;
          w_addr  = r_idx;
          w_wdata = C_INIT;
        end
        S_IDLE: begin
`ifdef SYNAPSE_WEIGHT_DECAY_EN
          if (!decay_req) begin
`else
          begin
`endif
            if (R_EN && !W_EN)
              w_rd_acc = 1'b1;
            if (W_EN && !R_EN) begin
              w_we    = 1'b1;
              w_wdata = w_mode ? w_sat : weight;
            end
          end
        end
`ifdef SYNAPSE_WEIGHT_DECAY_EN
        S_DECAY: begin
          w_we    = 1'b1;
          w_addr  = r_idx;
          w_wdata = (w_cur == '0) ? '0 : w_cur - WEIGHT_W'(1);
        end
`endif
        default: ;
      endcase
    end
  end

  // Weight array deliberately has no reset; the sweep defines its contents.
  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[w_addr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_weight <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= w_rd_acc;
      if (w_rd_acc)
        out_weight <= w_cur;
    end
  end

  assign busy = r_busy;

endmodule
`default_nettype wire

// File: doc/synapse_table.md
Name: synapse_table

Overview:
- Parametrised per-neuron synapse weight store that sits between the spike router and the neuron update logic.
- Indexed by presynaptic neuron number.
- Read port feeds the weight to the neuron; write port applies STDP updates, either as an overwrite or as a saturating signed delta.
- `kill` clears the whole table to the initial weight with a one-entry-per-cycle sweep; the same sweep runs automatically after reset.

Parameters:
- `NEURON_W`, 7, index width; table depth `DEPTH = 2**NEURON_W`.
- `WEIGHT_W`, 8, unsigned weight width.
- `DELTA_W`, 4, signed two's-complement STDP delta width.
- `INIT_WEIGHT`, 0, value written to every entry by the clear sweep; must fit in `WEIGHT_W`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `kill`  in  1  start clear sweep; level sampled each cycle.
- `neuron_number`  in  `NEURON_W`  entry index for read/write.
- `R_EN`  in  1  read request.
- `W_EN`  in  1  write request.
- `w_mode`  in  1  0 = overwrite with `weight`, 1 = add `delta`.
- `weight`  in  `WEIGHT_W`  overwrite value.
- `delta`  in  `DELTA_W`  signed STDP increment.
- `out_weight`  out  `WEIGHT_W`  registered read data.
- `out_valid`  out  1  one-cycle pulse, `out_weight` updated this cycle.
- `busy`  out  1  sweep in progress; requests ignored.

Behaviour:
- Storage: `DEPTH` × `WEIGHT_W` register array, no reset on the array itself. Content is defined only by the sweep.
- FSM states: `SWEEP`, `IDLE`. Sweep counter `idx` is `NEURON_W` bits.
- Reset (`rst`=0, asynchronous):
  - state=`SWEEP`, `idx`=0.
  - `out_weight`=0, `out_valid`=0, `busy`=1.
- `SWEEP` state:
  - Each rising edge writes `INIT_WEIGHT` to `mem[idx]` and increments `idx`.
  - The edge that writes entry `DEPTH-1` moves to `IDLE`, so `busy` is high for exactly `DEPTH` edges.
  - `busy` = (state==`SWEEP`), registered.
- `kill`=1 on any edge:
  - state←`SWEEP`, `idx`←0; this edge performs no write and no read.
  - `kill` during a sweep restarts it from 0.
  - Holding `kill` high keeps `idx` at 0; the sweep proceeds once `kill` drops.
  - `kill` has top priority over `R_EN`/`W_EN`.
- `IDLE` state, `kill`=0:
  - `R_EN`=1, `W_EN`=0: next edge `out_weight`←`mem[neuron_number]`, `out_valid`←1. Latency 1 cycle.
  - `R_EN`=0, `W_EN`=1, `w_mode`=0: `mem[neuron_number]`←`weight`.
  - `R_EN`=0, `W_EN`=1, `w_mode`=1: `mem[neuron_number]`←sat(`mem` + sign-extended `delta`).
    - Computed in `WEIGHT_W`+2-bit signed arithmetic.
    - Clamped to [0, 2**`WEIGHT_W`-1].
    - Single-cycle read-modify-write.
  - `R_EN`=1 and `W_EN`=1: illegal; no access, array unchanged, `out_valid`←0.
- `out_valid` is 0 on every edge without an accepted read. `out_weight` holds its last value.
- A read issued the cycle after a write to the same index returns the written value. There is no hazard, because the write completes on the same edge.
- Requests during `SWEEP` are dropped silently; no queueing. The upstream block must wait for `busy`=0.
- Reset asserted mid-sweep or mid-access: everything returns to the reset values above and a full sweep restarts.

Optional Feature:
- `SYNAPSE_WEIGHT_DECAY_EN` defined:
  - Adds input port `decay_req` (1 bit).
  - `decay_req`=1 in `IDLE` with `kill`=0 starts a `DECAY` state, which sweeps `idx` 0..`DEPTH-1`, one entry per cycle.
  - Each cycle performs `mem[idx]`←`mem[idx]`-1, saturating at 0.
  - `busy`=1 for `DEPTH` edges.
  - `kill` aborts `DECAY` and enters `SWEEP` at `idx` 0.
  - `decay_req` has priority over `R_EN`/`W_EN` in the same cycle.
- Not defined:
  - No `decay_req` port and no `DECAY` state.
  - Behaviour is identical to the above otherwise.

Test Plan:
- Reset release, defaults → `busy`=1 for exactly 128 edges, then 0. Reading all 128 entries returns 0 with `out_valid` one cycle after each `R_EN`.
- In `IDLE`, write overwrite idx 5 = 0xA3, next cycle read idx 5 → `out_weight`=0xA3, `out_valid` pulse width 1. Idx 4 and 6 still 0.
- Delta saturation:
  - idx 9 = 0xFE, delta +3 → read 0xFF.
  - idx 10 = 0x02, delta −8 → read 0x00.
  - idx 11 = 0x40, delta −1 → 0x3F.
- `kill` at sweep index 60 during a reset-initiated sweep → `busy` stays high 128 more edges. `R_EN` pulses during the sweep produce no `out_valid`. Afterwards idx 5 reads 0.
- `R_EN`=`W_EN`=1 on idx 7 holding 0x11 with `weight`=0x55 → `out_valid` stays 0, and a later read of idx 7 returns 0x11. Async `rst` pulse mid-read forces `out_valid`=0 and `out_weight`=0 immediately.
- With `SYNAPSE_WEIGHT_DECAY_EN`: idx 3 = 0x01, idx 4 = 0x80, `decay_req` pulse → `busy` 128 edges, then idx 3 = 0x00, idx 4 = 0x7F. A second decay leaves idx 3 at 0x00.
